// File: rtl/mx_blk_quant_if.sv
// ============================================================================
// Module      : mx_blk_quant_if
// Description : Input/output stream bundle for mx_blk_quant.
//               MXQ_SAT_FLAG_EN adds the o_sat element flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mx_blk_quant_if #(
  parameter int INT_W   = 24,
  parameter int SCALE_W = 8,
  parameter int ELEM_W  = 8
);
  logic                      i_valid;
  logic                      o_ready;
  logic signed [INT_W-1:0]   i_data;
  logic        [SCALE_W-1:0] i_scale;
  logic                      o_valid;
  logic                      i_ready;
  logic signed [ELEM_W-1:0]  o_data;
  logic        [SCALE_W-1:0] o_scale;
  logic                      o_last;
`ifdef MXQ_SAT_FLAG_EN
  logic                      o_sat;

  modport slave  (input  i_valid, i_data, i_scale, i_ready,
                  output o_ready, o_valid, o_data, o_scale, o_last, o_sat);
  modport master (output i_valid, i_data, i_scale, i_ready,
                  input  o_ready, o_valid, o_data, o_scale, o_last, o_sat);
`else
  modport slave  (input  i_valid, i_data, i_scale, i_ready,
                  output o_ready, o_valid, o_data, o_scale, o_last);
  modport master (output i_valid, i_data, i_scale, i_ready,
                  input  o_ready, o_valid, o_data, o_scale, o_last);
`endif
endinterface

`default_nettype wire

// File: rtl/mx_blk_quant.sv
// ============================================================================
// Module      : mx_blk_quant
// Description : Buffers a block of K (integer, scale) values, then emits them
//               as MXINT elements sharing the block's maximum scale.
//               Optional macro MXQ_SAT_FLAG_EN drives o_sat per element.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mx_blk_quant #(
  parameter int INT_W   = 24,
  parameter int SCALE_W = 8,
  parameter int ELEM_W  = 8,
  parameter int K       = 32
) (
  input  wire logic     i_clk,
  input  wire logic     i_rst,
  mx_blk_quant_if.slave bus
);
  localparam int CNT_W = $clog2(K);
  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_EMIT    = 1'b1;
  localparam logic [SCALE_W:0]   C_OFF       = (SCALE_W+1)'(INT_W - ELEM_W);
  localparam logic [SCALE_W:0]   C_SCALE_MAX = {1'b0, {SCALE_W{1'b1}}};
  localparam logic [SCALE_W+1:0] C_SH_LIM    = (SCALE_W+2)'(INT_W);
  localparam logic signed [INT_W:0] C_QMAX = (INT_W+1)'((2 ** (ELEM_W-1)) - 1);
  localparam logic signed [INT_W:0] C_QMIN = -C_QMAX;

  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_count;
  logic [SCALE_W-1:0] r_max_scale;
  logic               r_any_nz;
  logic [SCALE_W-1:0] r_scale;
  logic signed [INT_W-1:0] r_buf_d [K];
  logic [SCALE_W-1:0]      r_buf_s [K];

  logic               w_accept;
  logic               w_handshake;
  logic               w_last;
  logic               w_nz;
  logic [SCALE_W-1:0] w_max_next;
  logic [SCALE_W:0]   w_scale_sum;
  logic [SCALE_W-1:0] w_scale_sat;

  assign w_accept    = (r_state == S_COLLECT) && bus.i_valid;
  assign w_handshake = (r_state == S_EMIT) && bus.i_ready;
  assign w_last      = (r_count == CNT_W'(K - 1));
  assign w_nz        = (bus.i_data != '0);

  // Zero inputs carry no magnitude, so their scale must not raise the block max
  always_comb begin
    w_max_next = r_max_scale;
    if (w_nz && (!r_any_nz || (bus.i_scale > r_max_scale)))
      w_max_next = bus.i_scale;
  end

  assign w_scale_sum = {1'b0, w_max_next} + C_OFF;
  assign w_scale_sat = (w_scale_sum > C_SCALE_MAX) ? {SCALE_W{1'b1}}
                                                   : w_scale_sum[SCALE_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_COLLECT;
      r_count     <= '0;
      r_max_scale <= '0;
      r_any_nz    <= 1'b0;
      r_scale     <= '0;
    end else if (r_state == S_COLLECT) begin
      if (w_accept) begin
        r_count     <= r_count + 1'b1;
        r_max_scale <= w_max_next;
        r_any_nz    <= r_any_nz | w_nz;
        r_scale     <= (r_any_nz | w_nz) ? w_scale_sat : '0;
        if (w_last)
          r_state <= S_EMIT;
      end
    end else if (w_handshake) begin
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_state     <= S_COLLECT;
        r_max_scale <= '0;
        r_any_nz    <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_buf_d[r_count] <= bus.i_data;
      r_buf_s[r_count] <= bus.i_scale;
    end
  end

  // Quantisation of the entry currently addressed by r_count
  logic signed [INT_W-1:0] w_d;
  logic [SCALE_W-1:0]      w_s;
  logic [SCALE_W+1:0]      w_sh;
  logic signed [INT_W:0]   w_dx;
  logic signed [INT_W:0]   w_trunc;
  logic [INT_W-1:0]        w_mask_g;
  logic                    w_guard;
  logic                    w_sticky;
  logic                    w_round;
  logic signed [INT_W:0]   w_qpre;
  logic [ELEM_W-1:0]       w_q;
  logic                    w_sat;

  always_comb begin
    w_d      = r_buf_d[r_count];
    w_s      = r_buf_s[r_count];
    w_sh     = {2'b00, r_max_scale} - {2'b00, w_s} + {1'b0, C_OFF};
    w_dx     = {w_d[INT_W-1], w_d};
    w_trunc  = w_dx >>> w_sh;
    w_mask_g = (w_sh == '0) ? '0
                            : ({{(INT_W-1){1'b0}}, 1'b1} << (w_sh - 1'b1));
    w_guard  = |(w_d & w_mask_g);
    // mask_g - 1 covers every bit below the guard once mask_g is one-hot
    w_sticky = (w_mask_g != '0) && (|(w_d & (w_mask_g - 1'b1)));
    w_round  = w_guard && (w_sticky || w_trunc[0]);
    w_qpre   = w_trunc + $signed({{INT_W{1'b0}}, w_round});
    w_q      = '0;
    w_sat    = 1'b0;
    if ((w_d == '0) || (w_sh > C_SH_LIM)) begin
      w_q = '0;
    end else if (w_qpre > C_QMAX) begin
      w_q   = C_QMAX[ELEM_W-1:0];
      w_sat = 1'b1;
    end else if (w_qpre < C_QMIN) begin
      w_q   = C_QMIN[ELEM_W-1:0];
      w_sat = 1'b1;
    end else begin
      w_q = w_qpre[ELEM_W-1:0];
    end
  end

  assign bus.o_ready = (r_state == S_COLLECT);
  assign bus.o_valid = (r_state == S_EMIT);
  assign bus.o_data  = (r_state == S_EMIT) ? w_q : '0;
  assign bus.o_last  = (r_state == S_EMIT) && w_last;
  assign bus.o_scale = r_scale;
`ifdef MXQ_SAT_FLAG_EN
  assign bus.o_sat   = (r_state == S_EMIT) && w_sat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mx_blk_quant.sv
// ============================================================================
// Module      : tb_mx_blk_quant
// Description : Directed self-checking bench for mx_blk_quant (K=32).
//               Honours MXQ_SAT_FLAG_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mx_blk_quant;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mx_blk_quant_if #(.INT_W(24), .SCALE_W(8), .ELEM_W(8)) bus ();

  mx_blk_quant #(.INT_W(24), .SCALE_W(8), .ELEM_W(8), .K(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [23:0]       blk_d [32];
  logic [7:0]        blk_s [32];
  logic signed [7:0] exp_d [32];
  logic              exp_sat [32];
  logic [7:0]        exp_scale;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [23:0] d, input logic [7:0] s, input logic signed [7:0] q);
    for (int i = 0; i < 32; i++) begin
      blk_d[i] = d; blk_s[i] = s; exp_d[i] = q; exp_sat[i] = 1'b0;
    end
  endtask

  task automatic feed();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("ready_collect", bus.o_ready, 1'b1);
      bus.i_valid = 1'b1;
      bus.i_data  = blk_d[i];
      bus.i_scale = blk_s[i];
      @(posedge clk);
    end
  endtask

  task automatic drain(input bit stall);
    int n;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      // junk offered during EMIT must be ignored
      bus.i_valid = (j < 31);
      bus.i_data  = 24'h123456;
      bus.i_scale = 8'hFF;
      if (stall && ($urandom_range(0, 1) == 0)) begin
        bus.i_ready = 1'b0;
        n = $urandom_range(1, 3);
        repeat (n) begin
          @(negedge clk);
          chk("hold_data", bus.o_data, exp_d[j]);
          chk("hold_last", bus.o_last, (j == 31));
        end
        bus.i_ready = 1'b1;
      end
      chk("valid", bus.o_valid, 1'b1);
      chk("data", bus.o_data, exp_d[j]);
      chk("last", bus.o_last, (j == 31));
      chk("scale", bus.o_scale, exp_scale);
      chk("ready_emit", bus.o_ready, 1'b0);
`ifdef MXQ_SAT_FLAG_EN
      chk("sat", bus.o_sat, exp_sat[j]);
`endif
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("valid_after_block", bus.o_valid, 1'b0);
    chk("ready_after_block", bus.o_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_data = '0; bus.i_scale = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_ready", bus.o_ready, 1'b1);
    chk("rst_last", bus.o_last, 1'b0);
    chk("rst_scale", bus.o_scale, 8'd0);
    chk("rst_data", bus.o_data, 8'd0);
    rst = 1'b0;

    // 1: uniform block, exact values
    fill(24'h7F0000, 8'd0, 8'sd127); exp_scale = 8'd16;
    feed(); drain(1'b0);

    // 2: one larger scale sets the shared scale; stalled drain
    fill(24'h400000, 8'd0, 8'sd16); exp_scale = 8'd18;
    blk_s[0] = 8'd2; exp_d[0] = 8'sd64;
    feed(); drain(1'b1);

    // 3: round-to-nearest-even
    fill(24'h7F0000, 8'd0, 8'sd127); exp_scale = 8'd16;
    blk_d[1] = 24'h018000; exp_d[1] = 8'sd2;
    blk_d[2] = 24'h028000; exp_d[2] = 8'sd2;
    blk_d[3] = 24'h028001; exp_d[3] = 8'sd3;
    blk_d[4] = 24'hFE8000; exp_d[4] = -8'sd2;
    feed(); drain(1'b0);

    // 4: symmetric saturation
    fill(24'h7F0000, 8'd0, 8'sd127); exp_scale = 8'd16;
    blk_d[0] = 24'h7FFFFF; exp_d[0] = 8'sd127;  exp_sat[0] = 1'b1;
    blk_d[5] = 24'h800000; exp_d[5] = -8'sd127; exp_sat[5] = 1'b1;
    feed(); drain(1'b0);

    // 5a: all-zero block with assorted scales
    fill(24'h000000, 8'd0, 8'sd0); exp_scale = 8'd0;
    for (int i = 0; i < 32; i++) blk_s[i] = 8'(i * 7);
    feed(); drain(1'b0);

    // 5b: small-scale entries vanish beside max_scale=40
    fill(24'h000000, 8'd100, 8'sd0); exp_scale = 8'd56;
    blk_d[0] = 24'h7F0000; blk_s[0] = 8'd40; exp_d[0] = 8'sd127;
    blk_d[1] = 24'h7F0000; blk_s[1] = 8'd0;
    blk_d[2] = 24'h7F0000; blk_s[2] = 8'd16;
    feed(); drain(1'b0);

    // 5c: shared scale saturates at 255
    fill(24'h000000, 8'd0, 8'sd0); exp_scale = 8'd255;
    blk_d[0] = 24'h010000; blk_s[0] = 8'd250; exp_d[0] = 8'sd1;
    feed(); drain(1'b1);

    // 6: reset after 10 accepted entries discards the partial block
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b1; bus.i_data = 24'h7FFFFF; bus.i_scale = 8'd200;
      @(posedge clk);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", bus.o_valid, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_valid", bus.o_valid, 1'b0);
      chk("postrst_ready", bus.o_ready, 1'b1);
    end
    fill(24'h7F0000, 8'd0, 8'sd127); exp_scale = 8'd16;
    blk_d[1] = 24'h018000; exp_d[1] = 8'sd2;
    blk_d[4] = 24'hFE8000; exp_d[4] = -8'sd2;
    feed(); drain(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
